// File: rtl/audio_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | audio_pkg                                                            |
// | Shared constants for the board audio path (PDM capture, tone output) |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package audio_pkg;

   localparam int SYS_CLK_HZ  = 100_000_000;
   localparam int PDM_CLK_DIV = 25;
   localparam int PDM_DECIM   = 128;
   localparam int PCM_W       = 8;

   // Counter width able to hold 0..n-1, never narrower than one bit.
   function automatic int cnt_w(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage
`default_nettype wire

// File: rtl/pdm_mic_rx_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pdm_mic_rx_if                                                        |
// | PCM sample handshake between the PDM receiver and its consumer       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface pdm_mic_rx_if
   import audio_pkg::*;
#(
   parameter int W = PCM_W
);

   logic [W-1:0] sample;
   logic         sample_valid;
   logic         sample_ready;
   logic         overrun;

   modport master (
      output sample,
      output sample_valid,
      output overrun,
      input  sample_ready
   );

   modport slave (
      input  sample,
      input  sample_valid,
      input  overrun,
      output sample_ready
   );

endinterface
`default_nettype wire

// File: rtl/pdm_clkgen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pdm_clkgen                                                           |
// | Mic clock divider with a strobe in the cycle before each fall        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module pdm_clkgen
   import audio_pkg::*;
#(
   parameter int CLK_DIV = PDM_CLK_DIV
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   output logic m_clk,
   output logic strobe
);

   localparam int                c_HC_W    = cnt_w(CLK_DIV);
   localparam logic [c_HC_W-1:0] c_HC_LAST = c_HC_W'(CLK_DIV - 1);

   logic [c_HC_W-1:0] r_hc;
   logic              r_m_clk;

   always_ff @(posedge clk) begin
      if (rst || !en) begin
         r_hc    <= '0;
         r_m_clk <= 1'b0;
      end else if (r_hc == c_HC_LAST) begin
         r_hc    <= '0;
         r_m_clk <= ~r_m_clk;
      end else begin
         r_hc    <= r_hc + 1'b1;
      end
   end

   assign m_clk = r_m_clk;
   // Mic data is valid while M_CLK is high, so sample just before it falls.
   assign strobe = en && r_m_clk && (r_hc == c_HC_LAST);

endmodule
`default_nettype wire

// File: rtl/pdm_mic_rx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pdm_mic_rx                                                           |
// | PDM mic capture: clock gen, sync, boxcar decimator, PCM handshake    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module pdm_mic_rx
   import audio_pkg::*;
#(
   parameter int CLK_DIV = PDM_CLK_DIV,
   parameter int DECIM   = PDM_DECIM,
   parameter int OUT_W   = $clog2(DECIM + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             M_DATA,
   output logic             M_CLK,
   output logic             M_LR_SEL,
   pdm_mic_rx_if.master     pcm
);

   localparam int                c_BC_W    = cnt_w(DECIM);
   localparam logic [c_BC_W-1:0] c_BC_LAST = c_BC_W'(DECIM - 1);

   logic [1:0]       r_sync;
   logic [c_BC_W-1:0] r_bc;
   logic [OUT_W-1:0] r_acc;
   logic [OUT_W-1:0] r_sample;
   logic             r_valid;
   logic             r_overrun;

   logic             w_m_clk;
   logic             w_strobe;
   logic             w_d;
   logic             w_win_end;
   logic [OUT_W-1:0] w_result;

   pdm_clkgen #(
      .CLK_DIV (CLK_DIV)
   ) u_clkgen (
      .clk    (clk),
      .rst    (rst),
      .en     (en),
      .m_clk  (w_m_clk),
      .strobe (w_strobe)
   );

   assign w_d       = r_sync[1];
   assign w_result  = r_acc + OUT_W'(w_d);
   assign w_win_end = w_strobe && (r_bc == c_BC_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync <= '0;
      end else begin
         r_sync <= {r_sync[0], M_DATA};
      end
   end

   // Dropping en discards the partial window exactly like a reset does.
   always_ff @(posedge clk) begin
      if (rst || !en) begin
         r_bc  <= '0;
         r_acc <= '0;
      end else if (w_strobe) begin
         if (r_bc == c_BC_LAST) begin
            r_bc  <= '0;
            r_acc <= '0;
         end else begin
            r_bc  <= r_bc + 1'b1;
            r_acc <= w_result;
         end
      end
   end

   // A new result always wins; overrun flags a value lost to backpressure.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sample  <= '0;
         r_valid   <= 1'b0;
         r_overrun <= 1'b0;
      end else if (w_win_end) begin
         r_sample <= w_result;
         r_valid  <= 1'b1;
         if (r_valid && !pcm.sample_ready) begin
            r_overrun <= 1'b1;
         end
      end else if (r_valid && pcm.sample_ready) begin
         r_valid <= 1'b0;
      end
   end

   assign M_CLK            = w_m_clk;
   assign M_LR_SEL         = 1'b0;
   assign pcm.sample       = r_sample;
   assign pcm.sample_valid = r_valid;
   assign pcm.overrun      = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_pdm_mic_rx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_pdm_mic_rx                                                        |
// | Directed bench for pdm_mic_rx with CLK_DIV=2, DECIM=8                |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_pdm_mic_rx;

   localparam int CLK_DIV = 2;
   localparam int DECIM   = 8;
   localparam int OUT_W   = 4;

   logic clk    = 1'b0;
   logic rst    = 1'b1;
   logic en     = 1'b0;
   logic m_data = 1'b0;
   wire  m_clk;
   wire  m_lr_sel;

   int errors = 0;
   int checks = 0;

   pdm_mic_rx_if #(.W(OUT_W)) pcm ();

   pdm_mic_rx #(
      .CLK_DIV (CLK_DIV),
      .DECIM   (DECIM),
      .OUT_W   (OUT_W)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .M_DATA   (m_data),
      .M_CLK    (m_clk),
      .M_LR_SEL (m_lr_sel),
      .pcm      (pcm)
   );

   always #5 clk = ~clk;

   // Leaves the bench at the negedge where en rises: window-relative cycle 0.
   task automatic restart();
      @(negedge clk);
      rst = 1'b1; en = 1'b0; pcm.sample_ready = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0; en = 1'b1;
   endtask

   // One window: bit k is presented for the k-th strobe; rl drives ready in the load cycle.
   task automatic run_window(input logic [7:0] bits, input logic rb, input logic rl,
                             output logic [OUT_W-1:0] s_mid, output logic v_first);
      for (int k = 0; k < 8; k++) begin
         m_data = bits[k];
         pcm.sample_ready = rb;
         if (k == 7) begin
            repeat (3) @(negedge clk);
            pcm.sample_ready = rl;
            @(negedge clk);
         end else begin
            @(negedge clk);
            if (k == 0) v_first = pcm.sample_valid;
            repeat (3) @(negedge clk);
         end
         if (k == 3) s_mid = pcm.sample;
      end
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst = 1'b1; en = 1'b1; m_data = 1'b1; pcm.sample_ready = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({m_clk, m_lr_sel, pcm.sample, pcm.sample_valid, pcm.overrun} !== 8'b0) begin
         errors++;
         $display("FAIL reset_state: got mclk=%b lr=%b sample=%0d valid=%b ovr=%b, want all 0",
                  m_clk, m_lr_sel, pcm.sample, pcm.sample_valid, pcm.overrun);
      end
   endtask

   task automatic test_divider();
      logic exp_clk, exp_stb;
      restart();
      m_data = 1'b0;
      for (int n = 1; n <= 12; n++) begin
         @(negedge clk);
         exp_clk = (n >= 2) && (((n - 2) % 4) < 2);
         exp_stb = ((n % 4) == 3);
         checks++;
         if (m_clk !== exp_clk) begin
            errors++;
            $display("FAIL divider_mclk n=%0d: got %b want %b", n, m_clk, exp_clk);
         end
         checks++;
         if (dut.w_strobe !== exp_stb) begin
            errors++;
            $display("FAIL divider_strobe n=%0d: got %b want %b", n, dut.w_strobe, exp_stb);
         end
      end
      checks++;
      if (m_lr_sel !== 1'b0) begin
         errors++;
         $display("FAIL lr_sel: got %b want 0", m_lr_sel);
      end
   endtask

   task automatic test_levels();
      logic [OUT_W-1:0] s_mid;
      logic             v_first;
      logic [7:0]       pat  [3] = '{8'hFF, 8'h00, 8'h55};
      logic [OUT_W-1:0] want [3] = '{4'd8, 4'd0, 4'd4};
      restart();
      for (int w = 0; w < 3; w++) begin
         run_window(pat[w], 1'b1, 1'b1, s_mid, v_first);
         checks++;
         if (v_first !== 1'b0) begin
            errors++;
            $display("FAIL level_valid_pulse w=%0d: valid after window start got %b want 0", w, v_first);
         end
         checks++;
         if (pcm.sample !== want[w] || pcm.sample_valid !== 1'b1) begin
            errors++;
            $display("FAIL level_sample w=%0d: got %0d valid=%b want %0d valid=1",
                     w, pcm.sample, pcm.sample_valid, want[w]);
         end
      end
      @(negedge clk);
      checks++;
      if (pcm.sample_valid !== 1'b0 || pcm.overrun !== 1'b0) begin
         errors++;
         $display("FAIL level_valid_drop: got valid=%b ovr=%b want 0 0", pcm.sample_valid, pcm.overrun);
      end
   endtask

   task automatic test_backpressure();
      logic [OUT_W-1:0] s_mid;
      logic             v_first;
      restart();
      run_window(8'hFF, 1'b0, 1'b0, s_mid, v_first);
      checks++;
      if (pcm.sample !== 4'd8 || pcm.sample_valid !== 1'b1 || pcm.overrun !== 1'b0) begin
         errors++;
         $display("FAIL bp_first: got %0d valid=%b ovr=%b want 8 1 0",
                  pcm.sample, pcm.sample_valid, pcm.overrun);
      end
      run_window(8'h0F, 1'b0, 1'b0, s_mid, v_first);
      checks++;
      if (s_mid !== 4'd8) begin
         errors++;
         $display("FAIL bp_hold: mid-window sample got %0d want 8", s_mid);
      end
      checks++;
      if (pcm.sample !== 4'd4 || pcm.sample_valid !== 1'b1 || pcm.overrun !== 1'b1) begin
         errors++;
         $display("FAIL bp_overrun: got %0d valid=%b ovr=%b want 4 1 1",
                  pcm.sample, pcm.sample_valid, pcm.overrun);
      end
      pcm.sample_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (pcm.sample_valid !== 1'b0 || pcm.overrun !== 1'b1 || pcm.sample !== 4'd4) begin
         errors++;
         $display("FAIL bp_drain: got %0d valid=%b ovr=%b want 4 0 1",
                  pcm.sample, pcm.sample_valid, pcm.overrun);
      end
   endtask

   task automatic test_back_to_back();
      logic [OUT_W-1:0] s_mid;
      logic             v_first;
      restart();
      run_window(8'hFF, 1'b0, 1'b0, s_mid, v_first);
      run_window(8'h03, 1'b0, 1'b1, s_mid, v_first);
      checks++;
      if (pcm.sample !== 4'd2 || pcm.sample_valid !== 1'b1 || pcm.overrun !== 1'b0) begin
         errors++;
         $display("FAIL b2b_load_accept: got %0d valid=%b ovr=%b want 2 1 0",
                  pcm.sample, pcm.sample_valid, pcm.overrun);
      end
      @(negedge clk);
      checks++;
      if (pcm.sample_valid !== 1'b0) begin
         errors++;
         $display("FAIL b2b_consume: valid got %b want 0", pcm.sample_valid);
      end
   endtask

   task automatic test_abort_rst();
      logic [OUT_W-1:0] s_mid;
      logic             v_first;
      restart();
      run_window(8'hFF, 1'b0, 1'b0, s_mid, v_first);
      m_data = 1'b1;
      repeat (20) @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if ({m_clk, pcm.sample, pcm.sample_valid, pcm.overrun} !== 7'b0) begin
         errors++;
         $display("FAIL abort_rst_clear: got mclk=%b sample=%0d valid=%b ovr=%b want all 0",
                  m_clk, pcm.sample, pcm.sample_valid, pcm.overrun);
      end
      rst = 1'b0;
      run_window(8'hFF, 1'b1, 1'b1, s_mid, v_first);
      checks++;
      if (pcm.sample !== 4'd8 || pcm.sample_valid !== 1'b1) begin
         errors++;
         $display("FAIL abort_rst_next: got %0d valid=%b want 8 1", pcm.sample, pcm.sample_valid);
      end
   endtask

   task automatic test_abort_en();
      logic [OUT_W-1:0] s_mid;
      logic             v_first;
      restart();
      run_window(8'hFF, 1'b0, 1'b0, s_mid, v_first);
      m_data = 1'b1;
      repeat (20) @(negedge clk);
      en = 1'b0;
      for (int n = 0; n < 3; n++) begin
         @(negedge clk);
         checks++;
         if (m_clk !== 1'b0 || pcm.sample !== 4'd8 || pcm.sample_valid !== 1'b1) begin
            errors++;
            $display("FAIL abort_en_hold n=%0d: got mclk=%b sample=%0d valid=%b want 0 8 1",
                     n, m_clk, pcm.sample, pcm.sample_valid);
         end
      end
      en = 1'b1;
      run_window(8'hFF, 1'b0, 1'b1, s_mid, v_first);
      checks++;
      if (pcm.sample !== 4'd8 || pcm.sample_valid !== 1'b1 || pcm.overrun !== 1'b0) begin
         errors++;
         $display("FAIL abort_en_next: got %0d valid=%b ovr=%b want 8 1 0",
                  pcm.sample, pcm.sample_valid, pcm.overrun);
      end
   endtask

   task automatic test_sync_latency();
      restart();
      m_data = 1'b0;
      pcm.sample_ready = 1'b1;
      repeat (2) @(negedge clk);
      m_data = 1'b1;
      repeat (30) @(negedge clk);
      checks++;
      if (pcm.sample !== 4'd7 || pcm.sample_valid !== 1'b1) begin
         errors++;
         $display("FAIL sync_latency: got %0d valid=%b want 7 1", pcm.sample, pcm.sample_valid);
      end
   endtask

   initial begin
      pcm.sample_ready = 1'b0;
      test_reset();
      test_divider();
      test_levels();
      test_backpressure();
      test_back_to_back();
      test_abort_rst();
      test_abort_en();
      test_sync_latency();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
